id_ex_stage: RTL and testbench

Pipeline stage register between instruction decode and the execute-stage ALU of the 64-bit RISC-V core. Captures one decoded instruction per handshake, selects and forwards operands, and presents `alu_input1`, `alu_input2` and `alu_control` directly to the ALU. Owns EX/MEM and MEM/WB bypassing, load-use bubble insertion and branch flush.

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 64-bit RISC-V core. Holds one
//               decoded instruction, forwards operands from EX/MEM and MEM/WB,
//               inserts load-use bubbles, honours branch flush and drives the
//               ALU operand/opcode inputs directly.
//               Optional feature macro: ID_EX_FORWARDING_EN (bypass, operand
//               refresh and load-use detection). Without it the stage is a
//               plain one-entry buffer and decode resolves all RAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [3:0]      in_alu_control,
    input  logic            in_alu_src,
    input  logic            in_op1_pc,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,

    input  logic            flush,

    input  logic            exmem_reg_write,
    input  logic            exmem_mem_read,
    input  logic [4:0]      exmem_rd_addr,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd_addr,
    input  logic [XLEN-1:0] memwb_result,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_input1,
    output logic [XLEN-1:0] alu_input2,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            load_use_stall
);

    // Held instruction
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [3:0]      r_alu_control;
    logic            r_alu_src;
    logic            r_op1_pc;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_stall;
    logic            w_consume;
    logic            w_accept;

`ifdef ID_EX_FORWARDING_EN
    // Bypass select: EX/MEM beats MEM/WB; x0 is never a forwarding target
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && exmem_rd_addr == r_rs1_addr && r_rs1_addr != 5'd0)
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && memwb_rd_addr == r_rs1_addr && r_rs1_addr != 5'd0)
            w_fwd_rs1 = memwb_result;
        if (exmem_reg_write && exmem_rd_addr == r_rs2_addr && r_rs2_addr != 5'd0)
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && memwb_rd_addr == r_rs2_addr && r_rs2_addr != 5'd0)
            w_fwd_rs2 = memwb_result;
    end

    // A load in EX/MEM cannot supply data yet, so hold the consumer one bubble
    assign w_stall = r_valid && exmem_mem_read && exmem_rd_addr != 5'd0 &&
                     (exmem_rd_addr == r_rs1_addr || exmem_rd_addr == r_rs2_addr);
`else
    assign w_fwd_rs1 = r_rs1_data;
    assign w_fwd_rs2 = r_rs2_data;
    assign w_stall   = 1'b0;
`endif

    assign out_valid = r_valid && !w_stall;
    assign w_consume = out_valid && out_ready;
    assign in_ready  = !r_valid || w_consume;
    assign w_accept  = in_valid && in_ready;

    // Entry capture, flush/consume retirement and operand refresh while held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1_addr    <= 5'd0;
            r_rs2_addr    <= 5'd0;
            r_rd_addr     <= 5'd0;
            r_alu_control <= 4'd0;
            r_alu_src     <= 1'b0;
            r_op1_pc      <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
`ifdef ID_EX_FORWARDING_EN
            // Latch forwarded values so they survive the producer retiring
            if (r_valid && !w_consume) begin
                r_rs1_data <= w_fwd_rs1;
                r_rs2_data <= w_fwd_rs2;
            end
`endif
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid       <= 1'b1;
                r_pc          <= in_pc;
                r_rs1_data    <= in_rs1_data;
                r_rs2_data    <= in_rs2_data;
                r_imm         <= in_imm;
                r_rs1_addr    <= in_rs1_addr;
                r_rs2_addr    <= in_rs2_addr;
                r_rd_addr     <= in_rd_addr;
                r_alu_control <= in_alu_control;
                r_alu_src     <= in_alu_src;
                r_op1_pc      <= in_op1_pc;
                r_reg_write   <= in_reg_write;
                r_mem_read    <= in_mem_read;
                r_mem_write   <= in_mem_write;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign alu_input1     = r_op1_pc  ? r_pc  : w_fwd_rs1;
    assign alu_input2     = r_alu_src ? r_imm : w_fwd_rs2;
    assign out_store_data = w_fwd_rs2;
    assign out_pc         = r_pc;
    assign out_rd_addr    = r_rd_addr;
    assign alu_control    = r_valid ? r_alu_control : 4'd0;
    assign out_reg_write  = r_valid && r_reg_write;
    assign out_mem_read   = r_valid && r_mem_read;
    assign out_mem_write  = r_valid && r_mem_write;
    assign load_use_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage. Stimulus pushes expected
//               ALU-side transactions; a monitor pops them whenever the stage
//               hands an instruction to execute. Status outputs are checked
//               directly. Expectations follow ID_EX_FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_control;
    logic        in_alu_src, in_op1_pc, in_reg_write, in_mem_read, in_mem_write;
    logic        flush;
    logic        exmem_reg_write, exmem_mem_read;
    logic [4:0]  exmem_rd_addr;
    logic [63:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [63:0] memwb_result;
    logic        out_valid, out_ready;
    logic [63:0] alu_input1, alu_input2, out_store_data, out_pc;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write, load_use_stall;

    id_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_control(in_alu_control), .in_alu_src(in_alu_src), .in_op1_pc(in_op1_pc),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
        .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a1;
        logic [63:0] a2;
        logic [63:0] sd;
        logic [63:0] pc;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] sd,
                            input logic [63:0] pc, input logic [3:0] ctrl, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.sd = sd; e.pc = pc; e.ctrl = ctrl;
        e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
        q.push_back(e);
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1a, input logic [63:0] rs1d,
                             input logic [4:0] rs2a, input logic [63:0] rs2d, input logic [63:0] imm,
                             input logic [4:0] rd, input logic [3:0] ctrl, input logic src,
                             input logic op1pc, input logic rw, input logic mr, input logic mw);
        in_valid = 1'b1;
        in_pc = pc; in_rs1_addr = rs1a; in_rs1_data = rs1d;
        in_rs2_addr = rs2a; in_rs2_data = rs2d; in_imm = imm;
        in_rd_addr = rd; in_alu_control = ctrl; in_alu_src = src; in_op1_pc = op1pc;
        in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic clear_bypass();
        exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_rd_addr = 5'd0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd_addr = 5'd0; memwb_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every instruction handed to execute must match the queue head
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc 0x%0h expected no transaction", out_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_alu_input1", alu_input1, e.a1);
                chk("sb_alu_input2", alu_input2, e.a2);
                chk("sb_store_data", out_store_data, e.sd);
                chk("sb_pc", out_pc, e.pc);
                chk("sb_alu_control", {60'd0, alu_control}, {60'd0, e.ctrl});
                chk("sb_rd_addr", {59'd0, out_rd_addr}, {59'd0, e.rd});
                chk("sb_ctrl_bits", {61'd0, out_reg_write, out_mem_read, out_mem_write},
                    {61'd0, e.rw, e.mr, e.mw});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_instr('0, 5'd0, '0, 5'd0, '0, '0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        clear_bypass();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_alu_control", {60'd0, alu_control}, 64'd0);
        chk("reset_stall", {63'd0, load_use_stall}, 64'd0);
        step();
        rst_n = 1'b1;

        // ADDI x5,x0,7
        out_ready = 1'b1;
        set_instr(64'h100, 5'd0, '0, 5'd0, '0, 64'd7, 5'd5, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(64'd0, 64'd7, 64'd0, 64'h100, 4'b0010, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("addi_out_valid", {63'd0, out_valid}, 64'd1);

        // Forwarding priority on a held rs1 = x5
        step();
        out_ready = 1'b0;
        set_instr(64'h200, 5'd5, 64'd1, 5'd0, '0, 64'd3, 5'd7, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd5; exmem_result = 64'h10;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd5; memwb_result = 64'h20;
        @(negedge clk);
        chk("fwd_exmem_prio", alu_input1, FWD ? 64'h10 : 64'h1);
        step();
        exmem_reg_write = 1'b0;
        @(negedge clk);
        chk("fwd_memwb", alu_input1, FWD ? 64'h20 : 64'h1);
        step();
        out_ready = 1'b1;
        push_exp(FWD ? 64'h20 : 64'h1, 64'd3, 64'd0, 64'h200, 4'b0000, 5'd7, 1'b1, 1'b0, 1'b0);
        set_instr(64'h210, 5'd0, '0, 5'd0, '0, 64'd5, 5'd9, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 64'h99;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 64'h77;
        push_exp(64'd0, 64'd5, 64'd0, 64'h210, 4'b0110, 5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0_never_forwarded", alu_input1, 64'd0);

        // Load-use on rs2 = x6, then MEM/WB delivers the load data
        step();
        clear_bypass();
        out_ready = 1'b0;
        set_instr(64'h300, 5'd1, 64'h11, 5'd6, 64'h66, '0, 5'd8, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        exmem_mem_read = 1'b1; exmem_reg_write = 1'b1; exmem_rd_addr = 5'd6; exmem_result = 64'hDEAD;
        @(negedge clk);
        chk("load_use_stall", {63'd0, load_use_stall}, {63'd0, FWD});
        chk("load_use_out_valid", {63'd0, out_valid}, {63'd0, !FWD});
        chk("load_use_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        clear_bypass();
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd6; memwb_result = 64'hAB;
        out_ready = 1'b1;
        push_exp(64'h11, FWD ? 64'hAB : 64'h66, FWD ? 64'hAB : 64'h66, 64'h300, 4'b0000, 5'd8,
                 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("after_bubble_valid", {63'd0, out_valid}, 64'd1);

        // Operand refresh: MEM/WB forward present only in the first held cycle
        step();
        clear_bypass();
        out_ready = 1'b0;
        set_instr(64'h400, 5'd0, '0, 5'd9, 64'h9, '0, 5'd10, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd9; memwb_result = 64'h55;
        @(negedge clk);
        chk("held_out_valid", {63'd0, out_valid}, 64'd1);
        step();
        clear_bypass();
        @(negedge clk);
        chk("refresh_kept", alu_input2, FWD ? 64'h55 : 64'h9);
        step();
        step();
        out_ready = 1'b1;
        push_exp(64'd0, FWD ? 64'h55 : 64'h9, FWD ? 64'h55 : 64'h9, 64'h400, 4'b0000, 5'd10,
                 1'b1, 1'b0, 1'b0);
        step();

        // Flush coincident with an accept
        set_instr(64'h500, 5'd0, '0, 5'd0, '0, 64'd1, 5'd11, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_discard_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_discard_rw", {63'd0, out_reg_write}, 64'd0);

        // Flush of a held instruction
        step();
        out_ready = 1'b0;
        set_instr(64'h510, 5'd0, '0, 5'd0, '0, 64'd2, 5'd12, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_held_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_held_in_ready", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a load-use stall
        step();
        set_instr(64'h600, 5'd3, 64'h33, 5'd4, 64'h44, '0, 5'd13, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        exmem_mem_read = 1'b1; exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_result = 64'hBEEF;
        @(negedge clk);
        chk("pre_reset_stall", {63'd0, load_use_stall}, {63'd0, FWD});
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall", {63'd0, load_use_stall}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_alu_control", {60'd0, alu_control}, 64'd0);
        chk("rst_ctrl_bits", {61'd0, out_reg_write, out_mem_read, out_mem_write}, 64'd0);
        chk("rst_alu_input1", alu_input1, 64'd0);
        chk("rst_alu_input2", alu_input2, 64'd0);
        chk("rst_rd_addr", {59'd0, out_rd_addr}, 64'd0);
        step();
        rst_n = 1'b1;
        clear_bypass();

        // Four back-to-back instructions, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(64'h700 + 64'(4 * i), 5'd0, '0, 5'd0, '0, 64'(10 * i + 1), 5'(i + 1), 4'(i),
                      1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            push_exp(64'd0, 64'(10 * i + 1), 64'd0, 64'h700 + 64'(4 * i), 4'(i), 5'(i + 1),
                     1'b1, 1'b0, 1'b0);
            step();
            @(negedge clk);
            chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("b2b_drained", {63'd0, out_valid}, 64'd0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
